// File: rtl/timetag_pkg.sv
// Shared definitions for the record streamer: default record width,
// serializer state encoding and the bytes-per-record helper.
package timetag_pkg;

    localparam int REC_W_DEF = 48;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

    function automatic int num_bytes(input int rec_w);
        return rec_w / 8;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output.
// Ports: clk, rst_n (async low), push/din in, pop/dout out, level = stored count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guards keep level inside 0..DEPTH even if a caller misbehaves.
    assign do_push = push && (level != LW'(DEPTH));
    assign do_pop  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits so they wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/record_stream.sv
// Record streamer: buffers {lost_flag, record} words and serializes them
// LSB byte first over a data_rdy/data_ack byte handshake.
// Ports: record_rdy/record in; data_rdy/data/data_ack byte side;
// fifo_level, overflow (current lost flag), lost_count (saturating drops).
// Macro RECORD_STREAM_LOST_COUNT_EN enables the lost_count counter;
// without it lost_count is tied to 0.
module record_stream
    import timetag_pkg::*;
#(
    parameter int REC_W = REC_W_DEF,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     record_rdy,
    input  logic [REC_W-2:0]         record,
    output logic                     data_rdy,
    output logic [7:0]               data,
    input  logic                     data_ack,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         lost_count
);

    localparam int NB = num_bytes(REC_W);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(NB);

    logic             full;
    logic             accept;
    logic             drop;
    logic             lost_flag;
    logic             pop;
    logic             load;
    logic             adv;
    logic [REC_W-1:0] dout;
    logic [REC_W-1:0] shreg;
    logic [IW-1:0]    idx;

    ser_state_t state;
    ser_state_t state_nxt;

    // Full uses the registered level, so a same-cycle pop cannot
    // make room for an arriving record.
    assign full   = (fifo_level == LW'(DEPTH));
    assign accept = record_rdy && !full;
    assign drop   = record_rdy && full;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .din   ({lost_flag, record}),
        .dout  (dout),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_flag <= 1'b0;
        end else if (accept) begin
            lost_flag <= 1'b0;
        end else if (drop) begin
            lost_flag <= 1'b1;
        end
    end

    assign overflow = lost_flag;

`ifdef RECORD_STREAM_LOST_COUNT_EN
    logic [CNT_W-1:0] lost_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt <= '0;
        end else if (drop && (lost_cnt != '1)) begin
            lost_cnt <= lost_cnt + CNT_W'(1);
        end
    end

    assign lost_count = lost_cnt;
`else
    assign lost_count = '0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        adv       = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (data_ack) begin
                    if (idx == IW'(NB - 1)) begin
                        // Reload straight from the FIFO to avoid a gap.
                        if (fifo_level != '0) begin
                            pop  = 1'b1;
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shreg <= dout;
                idx   <= '0;
            end else if (adv) begin
                shreg <= shreg >> 8;
                idx   <= idx + IW'(1);
            end
        end
    end

    // The current byte always sits in the low bits of the shifter.
    assign data_rdy = (state == SEND);
    assign data     = shreg[7:0];

endmodule

// File: tb/tb_record_stream.sv
// Self-checking bench for record_stream (DEPTH=4, REC_W=48): vector table,
// scoreboard of expected bytes and hand-written corner sequences.
module tb_record_stream;

    localparam int REC_W = 48;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;
    localparam int NB    = REC_W / 8;

    logic              clk;
    logic              rst_n;
    logic              record_rdy;
    logic [REC_W-2:0]  record;
    logic              data_rdy;
    logic [7:0]        data;
    logic              data_ack;
    logic [2:0]        fifo_level;
    logic              overflow;
    logic [CNT_W-1:0]  lost_count;

    record_stream #(
        .REC_W (REC_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .record_rdy (record_rdy),
        .record     (record),
        .data_rdy   (data_rdy),
        .data       (data),
        .data_ack   (data_ack),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .lost_count (lost_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef RECORD_STREAM_LOST_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Reference model and scoreboard, evaluated at the falling edge.
    int         m_level = 0;
    bit         m_busy  = 1'b0;
    int         m_idx   = 0;
    bit         m_flag  = 1'b0;
    int         m_lost  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : model
        bit full;
        bit acc;
        bit drp;
        bit pop;
        logic [REC_W-1:0] w;
        if (!rst_n) begin
            m_level <= 0;
            m_busy  <= 1'b0;
            m_idx   <= 0;
            m_flag  <= 1'b0;
            m_lost  <= 0;
            exp_q.delete();
        end else begin
            chk("data_rdy", 64'(data_rdy), 64'(m_busy));
            chk("fifo_level", 64'(fifo_level), 64'(m_level));
            chk("overflow", 64'(overflow), 64'(m_flag));
            chk("lost_count", 64'(lost_count), 64'(exp_cnt(m_lost)));
            if (data_rdy && data_ack) begin
                obs_q.push_back(data);
                obs_t.push_back(cyc);
            end
            if (m_busy && data_ack) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 64'(data), 64'hdead);
                end else begin
                    chk("sb_byte", 64'(data), 64'(exp_q.pop_front()));
                end
            end
            full = (m_level == DEPTH);
            acc  = record_rdy && !full;
            drp  = record_rdy && full;
            pop  = 1'b0;
            if (!m_busy) begin
                if (m_level > 0) begin
                    pop = 1'b1;
                    m_busy <= 1'b1;
                    m_idx  <= 0;
                end
            end else if (data_ack) begin
                if (m_idx == NB - 1) begin
                    if (m_level > 0) begin
                        pop = 1'b1;
                        m_idx <= 0;
                    end else begin
                        m_busy <= 1'b0;
                    end
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
            m_level <= m_level + int'(acc) - int'(pop);
            if (acc) begin
                w = {m_flag, record};
                for (int b = 0; b < NB; b++) exp_q.push_back(w[b*8 +: 8]);
                m_flag <= 1'b0;
            end else if (drp) begin
                m_flag <= 1'b1;
                m_lost <= m_lost + 1;
            end
        end
    end

    typedef struct {
        logic [REC_W-2:0] rec;
        logic [7:0]       exp [NB];
    } vec_t;

    vec_t vecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [REC_W-2:0] r);
        record     = r;
        record_rdy = 1'b1;
        tick();
        record_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (m_busy || m_level != 0); i++) tick();
        chk("idle_timeout", 64'(m_busy || m_level != 0), 64'd0);
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 100 && obs_q.size() < n; i++) tick();
        chk("obs_count", 64'(obs_q.size()), 64'(n));
    endtask

    initial begin
        logic [REC_W-2:0] ra;

        vecs[0].rec = 47'h2A_BCDE_F012;
        vecs[0].exp = '{8'h12, 8'hF0, 8'hDE, 8'hBC, 8'h2A, 8'h00};
        vecs[1].rec = 47'h7FFF_FFFF_FFFF;
        vecs[1].exp = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        vecs[2].rec = 47'h1234_5678_9ABC;
        vecs[2].exp = '{8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12};

        rst_n      = 1'b0;
        record_rdy = 1'b0;
        record     = '0;
        data_ack   = 1'b0;
        repeat (3) tick();
        chk("rst_data_rdy", 64'(data_rdy), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_lost", 64'(lost_count), 64'd0);
        rst_n = 1'b1;

        // Single records from the table; the first strobe lands on the
        // first edge after reset release.
        data_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_idle();
            obs_q.delete();
            obs_t.delete();
            strobe(vecs[i].rec);
            chk("lat_edge_t", 64'(data_rdy), 64'd0);
            tick();
            chk("lat_edge_t1", 64'(data_rdy), 64'd1);
            wait_obs(NB);
            if (obs_q.size() >= NB) begin
                for (int b = 0; b < NB; b++)
                    chk($sformatf("vec%0d_byte%0d", i, b),
                        64'(obs_q[b]), 64'(vecs[i].exp[b]));
            end
            chk("vec_overflow", 64'(overflow), 64'd0);
        end

        // Back-to-back records must stream without a gap.
        wait_idle();
        obs_q.delete();
        obs_t.delete();
        for (int i = 0; i < 3; i++) begin
            record     = vecs[i].rec;
            record_rdy = 1'b1;
            tick();
        end
        record_rdy = 1'b0;
        wait_obs(3 * NB);
        if (obs_t.size() >= 3 * NB)
            chk("b2b_span", 64'(obs_t[3*NB-1] - obs_t[0]), 64'(3 * NB - 1));

        // Overflow: one record sits in the serializer, four in the FIFO,
        // so seven strobes lose two.
        wait_idle();
        data_ack   = 1'b0;
        record_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            record = 47'(i + 16'h100);
            tick();
        end
        record_rdy = 1'b0;
        chk("ovf_level", 64'(fifo_level), 64'd4);
        chk("ovf_lost", 64'(lost_count), 64'(exp_cnt(2)));
        chk("ovf_flag", 64'(overflow), 64'd1);
        data_ack = 1'b1;
        wait_idle();
        chk("ovf_flag_held", 64'(overflow), 64'd1);
        obs_q.delete();
        obs_t.delete();
        strobe(47'h0123_4567_89AB);
        chk("ovf_flag_clr", 64'(overflow), 64'd0);
        wait_obs(NB);
        if (obs_q.size() >= NB)
            chk("ovf_lost_bit", 64'(obs_q[NB-1][7]), 64'd1);

        // Full FIFO, record arrives on the final ack of a record.
        wait_idle();
        data_ack   = 1'b0;
        record_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            record = 47'(i + 16'h200);
            tick();
        end
        record_rdy = 1'b0;
        chk("fp_full", 64'(fifo_level), 64'(DEPTH));
        data_ack = 1'b1;
        repeat (NB - 1) tick();
        strobe(47'h7777);
        data_ack = 1'b0;
        chk("fp_level", 64'(fifo_level), 64'(DEPTH - 1));
        chk("fp_lost", 64'(lost_count), 64'(exp_cnt(3)));
        chk("fp_flag", 64'(overflow), 64'd1);
        data_ack = 1'b1;
        wait_idle();

        // Stall mid-record, then reset while byte 3 is presented.
        data_ack = 1'b0;
        ra = 47'h0055_6677_8899;
        strobe(ra);
        strobe(47'h0011_2233_4455);
        data_ack = 1'b1;
        tick();
        tick();
        data_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", 64'(data), 64'(ra[23:16]));
            tick();
        end
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
        chk("byte3_data", 64'(data), 64'(ra[31:24]));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rdy", 64'(data_rdy), 64'd0);
        chk("rst_mid_level", 64'(fifo_level), 64'd0);
        chk("rst_mid_data", 64'(data), 64'd0);
        chk("rst_mid_lost", 64'(lost_count), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        obs_q.delete();
        obs_t.delete();
        data_ack = 1'b1;
        repeat (10) tick();
        chk("post_rst_bytes", 64'(obs_q.size()), 64'd0);
        chk("post_rst_rdy", 64'(data_rdy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
